// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: turns decoder load/store controls into a
// req/ack data-memory transaction, stalls while it is outstanding, and formats load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Loadop,
    input  logic [1:0]  Saveop,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic        op_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LBU  = 3'b010;
    localparam logic [2:0] LD_LH   = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_NONE = 3'b111;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_load_q, is_load_d;
    logic [2:0]       lop_q, lop_d;
    logic [1:0]       off_q, off_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;
    logic             load_valid_q, load_valid_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             addr_err_q, addr_err_d;
    logic             op_err_q, op_err_d;
    logic             bus_err_q, bus_err_d;
    logic             stall_c;

    logic        start, illegal, misaligned, is_byte, is_half;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request decode: access size, legality and alignment
    always_comb begin
        start   = MemRead | MemWrite;
        illegal = (MemRead & MemWrite) | (MemRead & (Loadop == LD_NONE))
                | (MemWrite & (Saveop == ST_NONE));
        if (MemRead) begin
            is_byte = (Loadop == LD_LB) | (Loadop == LD_LBU);
            is_half = (Loadop == LD_LH) | (Loadop == LD_LHU);
        end else begin
            is_byte = (Saveop == ST_SB);
            is_half = (Saveop == ST_SH);
        end
        misaligned = is_byte ? 1'b0 : (is_half ? addr[0] : (|addr[1:0]));
        rd_byte    = 8'(dmem_rdata >> {off_q, 3'b000});
        rd_half    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        lop_d        = lop_q;
        off_d        = off_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        addr_err_d   = 1'b0;
        op_err_d     = 1'b0;
        bus_err_d    = 1'b0;
        stall_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (illegal) begin
                        op_err_d = 1'b1;
                    end else if (misaligned) begin
                        addr_err_d = 1'b1;
                    end else begin
                        stall_c     = 1'b1;
                        state_d     = S_WAIT;
                        cnt_d       = '0;
                        is_load_d   = MemRead;
                        lop_d       = Loadop;
                        off_d       = addr[1:0];
                        dmem_req_d  = 1'b1;
                        dmem_we_d   = MemWrite;
                        dmem_addr_d = {addr[31:2], 2'b00};
                        if (MemRead) begin
                            dmem_be_d    = 4'b1111;
                            dmem_wdata_d = '0;
                        end else if (Saveop == ST_SB) begin
                            dmem_be_d    = 4'b0001 << addr[1:0];
                            dmem_wdata_d = {4{store_data[7:0]}};
                        end else if (Saveop == ST_SH) begin
                            dmem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                            dmem_wdata_d = {2{store_data[15:0]}};
                        end else begin
                            dmem_be_d    = 4'b1111;
                            dmem_wdata_d = store_data;
                        end
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    state_d    = S_RESP;
                    if (is_load_q) begin
                        load_valid_d = 1'b1;
                        case (lop_q)
                            LD_LB:   load_data_d = {{24{rd_byte[7]}}, rd_byte};
                            LD_LBU:  load_data_d = {24'd0, rd_byte};
                            LD_LH:   load_data_d = {{16{rd_half[15]}}, rd_half};
                            LD_LHU:  load_data_d = {16'd0, rd_half};
                            default: load_data_d = dmem_rdata;
                        endcase
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    dmem_req_d = 1'b0;
                    state_d    = S_RESP;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Same instruction is still presented here, so MemRead/MemWrite are ignored
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            lop_q        <= '0;
            off_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            addr_err_q   <= 1'b0;
            op_err_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            lop_q        <= lop_d;
            off_q        <= off_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            addr_err_q   <= addr_err_d;
            op_err_q     <= op_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall      = stall_c & ~rst;
    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign addr_err   = addr_err_q;
    assign op_err     = op_err_q;
    assign bus_err    = bus_err_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// multi-cycle sequences and randomized ops against a behavioural model.
module tb_mem_access_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  Loadop;
    logic [1:0]  Saveop;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, addr_err, op_err, bus_err;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Loadop(Loadop), .Saveop(Saveop), .addr(addr), .store_data(store_data),
        .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .addr_err(addr_err), .op_err(op_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_ld = 32'h0;

    // kind: 0 access, 1 misaligned, 2 illegal, 3 no request
    typedef struct {
        int kind; logic we; logic [31:0] waddr; logic [3:0] be; logic [31:0] wdata;
        int stall; int reqc; int lv; int bus; logic [31:0] ld;
    } exp_t;

    typedef struct {
        int stall; int reqc; int first_req; int unstable; int lv; int ae; int oe; int bus;
        logic we; logic [31:0] waddr; logic [3:0] be; logic [31:0] wdata;
        logic [31:0] lv_data; logic [31:0] ld_end;
    } res_t;

    typedef struct {
        logic mr; logic mw; logic [2:0] lop; logic [1:0] sop;
        logic [31:0] a; logic [31:0] sd; logic [31:0] rd; int aw;
        int kind; logic [3:0] be; logic [31:0] wdata; logic [31:0] ld; int stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: expected transaction from the load/store rules, in plain arithmetic
    function automatic exp_t model(input logic mr, input logic mw, input logic [2:0] lop,
                                   input logic [1:0] sop, input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rd, input int aw, input logic [31:0] prev);
        exp_t e;
        int size;
        int off;
        longint v;
        e = '{default: 0};
        e.ld = prev;
        off = int'(a % 4);
        if (!mr && !mw) begin e.kind = 3; return e; end
        if ((mr && mw) || (mr && lop == 3'd7) || (mw && sop == 2'd3)) begin e.kind = 2; return e; end
        if (mr) size = (lop == 3'd1 || lop == 3'd2) ? 1 : ((lop == 3'd3 || lop == 3'd4) ? 2 : 4);
        else    size = (sop == 2'd1) ? 1 : ((sop == 2'd2) ? 2 : 4);
        if (off % size != 0) begin e.kind = 1; return e; end
        e.kind  = 0;
        e.we    = mw;
        e.waddr = a - 32'(off);
        if (mw) begin
            e.be    = 4'(((1 << size) - 1) << off);
            e.wdata = (size == 4) ? sd : ((size == 2) ? (sd % 65536) * 32'h00010001
                                                      : (sd % 256) * 32'h01010101);
        end else begin
            e.be = 4'hF;
        end
        if (aw < 0) begin
            e.reqc = TO; e.stall = TO + 1; e.bus = 1;
        end else begin
            e.reqc = aw + 1; e.stall = aw + 2;
            if (mr) begin
                e.lv = 1;
                v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * size));
                if ((lop == 3'd1 || lop == 3'd3) && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                e.ld = 32'(v);
            end
        end
        return e;
    endfunction

    // Present one instruction from a negedge until it is no longer stalled; acts as memory
    task automatic run_op(input logic mr, input logic mw, input logic [2:0] lop, input logic [1:0] sop,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int aw, input bit trail, output res_t r);
        bit done;
        int cyc;
        done = 0;
        cyc  = 0;
        r = '{default: 0};
        r.first_req = -1;
        MemRead = mr; MemWrite = mw; Loadop = lop; Saveop = sop;
        addr = a; store_data = sd; dmem_ack = 1'b0;
        while (!done && cyc < 64) begin
            #1;
            if (stall) r.stall++;
            if (dmem_req) begin
                if (r.reqc == 0) begin
                    r.first_req = cyc; r.we = dmem_we; r.waddr = dmem_addr;
                    r.be = dmem_be; r.wdata = dmem_wdata;
                end else if (dmem_we !== r.we || dmem_addr !== r.waddr ||
                             dmem_be !== r.be || dmem_wdata !== r.wdata) begin
                    r.unstable++;
                end
                r.reqc++;
                if (aw >= 0 && r.reqc - 1 == aw) begin dmem_ack = 1'b1; dmem_rdata = rd; end
                else begin dmem_ack = 1'b0; dmem_rdata = $urandom; end
            end else begin
                dmem_ack = 1'b0;
            end
            if (load_valid) begin r.lv++; r.lv_data = load_data; end
            if (addr_err) r.ae++;
            if (op_err) r.oe++;
            if (bus_err) r.bus++;
            if (!stall) done = 1;
            cyc++;
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        if (!done) chk("cycle_bound", 32'd0, 32'd1);
        if (trail) begin
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            if (load_valid) r.lv++;
            if (addr_err) r.ae++;
            if (op_err) r.oe++;
            if (bus_err) r.bus++;
            @(negedge clk);
        end
        r.ld_end = load_data;
    endtask

    task automatic check_res(input string tag, input res_t r, input exp_t e);
        chk({tag, " stall_cycles"}, r.stall, e.stall);
        chk({tag, " addr_err"}, r.ae, (e.kind == 1) ? 1 : 0);
        chk({tag, " op_err"}, r.oe, (e.kind == 2) ? 1 : 0);
        chk({tag, " req_cycles"}, r.reqc, e.reqc);
        chk({tag, " bus_err"}, r.bus, e.bus);
        chk({tag, " load_valid"}, r.lv, e.lv);
        chk({tag, " load_data"}, r.ld_end, e.ld);
        if (e.kind == 0) begin
            chk({tag, " first_req"}, r.first_req, 1);
            chk({tag, " req_stable"}, r.unstable, 0);
            chk({tag, " we"}, {31'd0, r.we}, {31'd0, e.we});
            chk({tag, " dmem_addr"}, r.waddr, e.waddr);
            chk({tag, " be"}, {28'd0, r.be}, {28'd0, e.be});
            if (e.we) chk({tag, " wdata"}, r.wdata, e.wdata);
            if (e.lv != 0) chk({tag, " lv_data"}, r.lv_data, e.ld);
        end
    endtask

    initial begin
        vec_t vecs[14];
        res_t r;
        exp_t e;
        int   cnt;

        vecs[0]  = '{1'b0, 1'b1, 3'd7, 2'd1, 32'h1003, 32'h000000A5, 32'h0, 2, 0, 4'b1000, 32'hA5A5A5A5, 32'h0, 4};
        vecs[1]  = '{1'b1, 1'b0, 3'd1, 2'd3, 32'h2001, 32'h0, 32'h00008000, 0, 0, 4'hF, 32'h0, 32'hFFFFFF80, 2};
        vecs[2]  = '{1'b1, 1'b0, 3'd2, 2'd3, 32'h2001, 32'h0, 32'h00008000, 0, 0, 4'hF, 32'h0, 32'h00000080, 2};
        vecs[3]  = '{1'b1, 1'b0, 3'd3, 2'd3, 32'h2002, 32'h0, 32'h80000000, 1, 0, 4'hF, 32'h0, 32'hFFFF8000, 3};
        vecs[4]  = '{1'b1, 1'b0, 3'd4, 2'd3, 32'h2002, 32'h0, 32'h80000000, 0, 0, 4'hF, 32'h0, 32'h00008000, 2};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 2'd3, 32'h2002, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0, 0};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 2'd0, 32'h2002, 32'h0, 32'h0, 0, 2, 4'h0, 32'h0, 32'h0, 0};
        vecs[7]  = '{1'b0, 1'b1, 3'd7, 2'd2, 32'h0010, 32'h1234ABCD, 32'h0, 1, 0, 4'b0011, 32'hABCDABCD, 32'h0, 3};
        vecs[8]  = '{1'b0, 1'b1, 3'd7, 2'd0, 32'h0020, 32'hDEADBEEF, 32'h0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0, 2};
        vecs[9]  = '{1'b1, 1'b0, 3'd7, 2'd3, 32'h0030, 32'h0, 32'h0, 0, 2, 4'h0, 32'h0, 32'h0, 0};
        vecs[10] = '{1'b0, 1'b1, 3'd7, 2'd3, 32'h0030, 32'h0, 32'h0, 0, 2, 4'h0, 32'h0, 32'h0, 0};
        vecs[11] = '{1'b0, 1'b1, 3'd7, 2'd2, 32'h0013, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0, 0};
        vecs[12] = '{1'b1, 1'b0, 3'd0, 2'd3, 32'h0044, 32'h0, 32'h12345678, 3, 0, 4'hF, 32'h0, 32'h12345678, 5};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 2'd1, 32'h0002, 32'h00000077, 32'h0, 0, 0, 4'b0100, 32'h77777777, 32'h0, 2};

        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Loadop = 3'd7; Saveop = 2'd3;
        addr = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst dmem_wdata", dmem_wdata, 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst pulses", {28'd0, load_valid, addr_err, op_err, bus_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            e = '{default: 0};
            e.kind  = vecs[i].kind;
            e.we    = vecs[i].mw;
            e.waddr = {vecs[i].a[31:2], 2'b00};
            e.be    = vecs[i].be;
            e.wdata = vecs[i].wdata;
            e.stall = vecs[i].stall;
            e.reqc  = (vecs[i].kind == 0) ? vecs[i].stall - 1 : 0;
            e.lv    = (vecs[i].kind == 0 && vecs[i].mr) ? 1 : 0;
            e.ld    = (e.lv != 0) ? vecs[i].ld : model_ld;
            run_op(vecs[i].mr, vecs[i].mw, vecs[i].lop, vecs[i].sop, vecs[i].a,
                   vecs[i].sd, vecs[i].rd, vecs[i].aw, 1'b1, r);
            check_res($sformatf("vec%0d", i), r, e);
            model_ld = e.ld;
        end

        // Timeout: ack never arrives, load_data must keep the previous value
        e = model(1'b1, 1'b0, 3'd0, 2'd3, 32'h40, 32'h0, 32'h0, -1, model_ld);
        run_op(1'b1, 1'b0, 3'd0, 2'd3, 32'h40, 32'h0, 32'h0, -1, 1'b1, r);
        check_res("timeout", r, e);
        chk("timeout req_16", r.reqc, 16);

        // Back-to-back SW then LW with immediate ack
        e = model(1'b0, 1'b1, 3'd7, 2'd0, 32'h80, 32'h11223344, 32'h0, 0, model_ld);
        run_op(1'b0, 1'b1, 3'd7, 2'd0, 32'h80, 32'h11223344, 32'h0, 0, 1'b0, r);
        check_res("b2b_sw", r, e);
        e = model(1'b1, 1'b0, 3'd0, 2'd3, 32'h84, 32'h0, 32'hCAFEF00D, 0, model_ld);
        run_op(1'b1, 1'b0, 3'd0, 2'd3, 32'h84, 32'h0, 32'hCAFEF00D, 0, 1'b1, r);
        check_res("b2b_lw", r, e);
        model_ld = e.ld;

        // Reset asserted mid-WAIT
        MemRead = 1'b1; MemWrite = 1'b0; Loadop = 3'd0; Saveop = 2'd3; addr = 32'h40;
        dmem_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("midrst req_before", {31'd0, dmem_req}, 32'd1);
        #2 rst = 1'b1;
        MemRead = 1'b0;
        #1;
        chk("midrst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst stall", {31'd0, stall}, 32'd0);
        chk("midrst load_data", load_data, 32'd0);
        chk("midrst dmem_be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (load_valid || addr_err || op_err || bus_err || dmem_req || stall) cnt++;
            @(negedge clk);
        end
        chk("midrst quiet_after", cnt, 0);
        model_ld = 32'h0;

        for (int i = 0; i < 120; i++) begin
            logic mr, mw;
            logic [2:0] lop;
            logic [1:0] sop;
            logic [31:0] a;
            int sel, aw;
            sel = int'($urandom_range(0, 9));
            mr  = (sel < 5);
            mw  = (sel >= 4 && sel < 9);
            lop = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
            sop = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            aw  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 3));
            e = model(mr, mw, lop, sop, a, $urandom, 32'h0, aw, model_ld);
            e = model(mr, mw, lop, sop, a, store_data_pick(i), rdata_pick(i), aw, model_ld);
            run_op(mr, mw, lop, sop, a, store_data_pick(i), rdata_pick(i), aw, 1'b1, r);
            check_res($sformatf("rnd%0d", i), r, e);
            model_ld = e.ld;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Deterministic per-iteration data so model and stimulus see identical values
    function automatic logic [31:0] store_data_pick(input int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] rdata_pick(input int i);
        return 32'(i) * 32'h85EBCA77 + 32'h8000_7F81;
    endfunction
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store engine directly downstream of the instruction decoder.
- Consumes the decoder's MemRead, MemWrite, Loadop and Saveop together with the ALU-computed effective address and the rt store data.
- Drives a variable-latency req/ack data-memory port with byte enables.
- Stalls the pipeline while an access is outstanding.
- Returns sign- or zero-extended load data to writeback.

Parameters:
TIMEOUT, 16, cycles to wait for dmem_ack before aborting; 0 disables the timeout.
CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
MemRead  input  1  load request from the decoder.
MemWrite  input  1  store request from the decoder.
Loadop  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 111 none.
Saveop  input  2  00 SW, 01 SB, 10 SH, 11 none.
addr  input  32  effective byte address.
store_data  input  32  rt value.
stall  output  1  freeze upstream stages (combinational).
load_valid  output  1  one-cycle pulse; load_data valid.
load_data  output  32  extended load result.
addr_err  output  1  one-cycle pulse: misaligned access.
op_err  output  1  one-cycle pulse: illegal control combination.
bus_err  output  1  one-cycle pulse: timeout abort.
dmem_req  output  1  memory request (registered).
dmem_we  output  1  1 = write.
dmem_addr  output  32  word address; {addr[31:2],2'b00}.
dmem_be  output  4  byte enables; lane0 = bits 7:0.
dmem_wdata  output  32  lane-replicated store data.
dmem_ack  input  1  memory completion; one cycle.
dmem_rdata  input  32  read word; valid with dmem_ack.

Behaviour:
Reset:
- state=IDLE.
- All outputs 0, including load_data and dmem_*.
- Timeout counter 0.
- Asserting rst mid-access drops dmem_req immediately; the access is abandoned and no pulse is emitted.

States: IDLE, WAIT, RESP.

start = MemRead | MemWrite, sampled in IDLE only.

Illegal control (op_err):
- Occurs when MemRead & MemWrite, MemRead with Loadop=111, or MemWrite with Saveop=11.
- No access, no stall; op_err pulses the next cycle.

Misalignment (addr_err):
- Word ops with addr[1:0]!=0, or half ops with addr[0]!=0.
- No access, no stall; addr_err pulses the next cycle.
- op_err takes precedence over addr_err.

Legal start in IDLE:
- stall=1 in the same cycle.
- Next edge: latch op and addr[1:0]; dmem_req=1 with dmem_we, dmem_addr, dmem_be, dmem_wdata; state=WAIT; counter cleared.

WAIT:
- stall=1.
- dmem_req and all dmem_* outputs held stable until dmem_ack.
- On dmem_ack: dmem_req=0 at the next edge; state=RESP; for loads, load_data registered.
- Without ack, the counter increments each cycle. When it reaches TIMEOUT-1 with no ack: dmem_req=0, state=RESP, bus_err flagged.
- An ack arriving in the timeout cycle wins.

RESP (exactly one cycle):
- stall=0.
- load_valid=1 for loads that did not time out.
- bus_err=1 if the access aborted.
- MemRead/MemWrite are ignored here because the same instruction is still presented.
- Next state IDLE.

Access latency: minimum 3 cycles from start to release (start, WAIT with immediate ack, RESP).

Store formatting:
- SW: be=1111, wdata=store_data.
- SH: be=0011 when addr[1]=0, 1100 when addr[1]=1; wdata={2{store_data[15:0]}}.
- SB: be=0001<<addr[1:0]; wdata={4{store_data[7:0]}}.

Load formatting:
- Byte lane selected by addr[1:0]; half lane selected by addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reads drive be=1111.
- load_data holds its value until the next load completes.

Test Plan:
1. Reset asserted mid-WAIT -> dmem_req falls asynchronously; all outputs 0; state IDLE; no pulses emitted after release.
2. SB, addr=0x1003, store_data=0x000000A5, ack after 2 WAIT cycles -> dmem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, dmem_we=1; stall high for 4 cycles; no load_valid.
3. LB at addr 0x2001 with rdata 0x00008000 -> load_data=0xFFFFFF80; LBU with the same inputs -> 0x00000080; LH at addr 0x2002 with rdata 0x80000000 -> 0xFFFF8000; load_valid pulses one cycle in RESP.
4. LW at addr 0x2002 -> no dmem_req, stall=0, addr_err pulses once. MemRead=MemWrite=1 -> op_err pulses once, addr_err=0.
5. LW with ack never asserted and TIMEOUT=16 -> dmem_req held 16 cycles then drops; bus_err pulses; load_valid=0; load_data unchanged.
6. Back-to-back SW then LW with ack in the first WAIT cycle -> each access takes 3 cycles, no cycle lost between them, and the second request is issued the cycle after the first RESP.
